// File: rtl/ccip_rd_arbiter.sv
// Round-robin, credit-limited arbiter sharing the CCI-P channel-0 read path among N_REQ requesters.
// Each read carries its requester index in mdata[15:8] so the response can be steered back.
module ccip_rd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_OUT = 64,
  parameter int ADDR_W  = 42
) (
  input  logic                    clk,
  input  logic                    spl_reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    spl_tx_rd_almostfull,
  output logic                    tx_rd_valid,
  output logic [ADDR_W-1:0]       tx_rd_addr,
  output logic [15:0]             tx_rd_mdata,
  input  logic                    rx_rd_valid,
  input  logic [15:0]             rx_rd_mdata,
  input  logic [511:0]            rx_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [511:0]            rsp_data,
  input  logic                    quiesce,
  output logic                    idle,
  output logic [7:0]              outstanding,
  output logic                    err_bad_rsp
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [7:0]       seq;
  logic             can_issue_p0;
  logic             grant_vld_p0;
  logic [IDX_W-1:0] grant_idx_p0;
  logic [IDX_W-1:0] cand_p0;
  logic [7:0]       rsp_idx_p0;
  logic             rsp_ok_p0;
  logic [N_REQ-1:0] rsp_sel_p0;
  logic             unused_seq;

  // The response's sequence byte is informational only; routing uses the index byte.
  assign unused_seq = ^rx_rd_mdata[7:0];

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
    if (int'(g) == N_REQ - 1) return '0;
    return g + IDX_W'(1);
  endfunction

  // Stage p0: same-cycle round-robin grant starting at rr_ptr
  always_comb begin
    can_issue_p0 = !spl_tx_rd_almostfull && (int'(outstanding) < MAX_OUT) &&
                   !quiesce && !spl_reset;
    grant_vld_p0 = 1'b0;
    grant_idx_p0 = '0;
    cand_p0      = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (can_issue_p0 && !grant_vld_p0 && req_valid[cand_p0]) begin
        grant_vld_p0 = 1'b1;
        grant_idx_p0 = cand_p0;
      end
      cand_p0 = ptr_after(cand_p0);
    end
    req_ready = '0;
    if (grant_vld_p0) req_ready[grant_idx_p0] = 1'b1;
  end

  // Stage p0: response qualification; a response with nothing in flight is an underflow
  always_comb begin
    rsp_idx_p0 = rx_rd_mdata[15:8];
    rsp_ok_p0  = rx_rd_valid && (int'(rsp_idx_p0) < N_REQ) && (outstanding != 8'd0);
    rsp_sel_p0 = '0;
    for (int i = 0; i < N_REQ; i++) rsp_sel_p0[i] = rsp_ok_p0 && (int'(rsp_idx_p0) == i);
  end

  // Stage p1: registered issue, response strobe and credit count
  always_ff @(posedge clk) begin
    if (spl_reset) begin
      rr_ptr      <= '0;
      seq         <= '0;
      tx_rd_valid <= 1'b0;
      tx_rd_addr  <= '0;
      tx_rd_mdata <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      outstanding <= '0;
      err_bad_rsp <= 1'b0;
    end else begin
      tx_rd_valid <= grant_vld_p0;
      if (grant_vld_p0) begin
        tx_rd_addr  <= req_addr[int'(grant_idx_p0)*ADDR_W +: ADDR_W];
        tx_rd_mdata <= {8'(grant_idx_p0), seq};
        seq         <= seq + 8'd1;
        rr_ptr      <= ptr_after(grant_idx_p0);
      end
      rsp_valid <= rsp_sel_p0;
      if (rsp_ok_p0) rsp_data <= rx_data;
      if (rx_rd_valid && !rsp_ok_p0) err_bad_rsp <= 1'b1;
      case ({grant_vld_p0, rsp_ok_p0})
        2'b10:   outstanding <= outstanding + 8'd1;
        2'b01:   outstanding <= outstanding - 8'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign idle = (outstanding == 8'd0) && !tx_rd_valid;

endmodule
